// File: rtl/tabla_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// tabla_sweep_ctrl
//   Exhaustive sweep sequencer for a bank of small combinational truth-table
//   units. On an accepted start it walks vec_out through 0..2^N_IN-1. Each
//   vector is held for SETTLE cycles plus one sample cycle. The selected
//   unit's output bit is captured into tabla[vector].
//
// Ports
//   clk       rising-edge clock
//   rst_n     async active-low reset
//   start     sweep request, only looked at in IDLE
//   func_sel  unit index, latched when start is accepted
//   unit_y    one output bit per unit (bit i = unit i)
//   vec_out   shared input vector driven to every unit (MSB = A)
//   unit_en   one-hot enable of the latched unit while busy
//   busy      high in SETTLE / SAMPLE / DONE
//   done      one-cycle pulse, tabla valid
//   tabla     captured truth table, bit k = f(vector k)
//   err       one-cycle pulse for a start with an out-of-range func_sel
// -----------------------------------------------------------------------------
module tabla_sweep_ctrl #(
  parameter int N_IN   = 4,
  parameter int N_FUNC = 5,
  parameter int SETTLE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [2:0]        func_sel,
  input  logic [N_FUNC-1:0] unit_y,
  output logic [N_IN-1:0]   vec_out,
  output logic [N_FUNC-1:0] unit_en,
  output logic              busy,
  output logic              done,
  output logic [15:0]       tabla,
  output logic              err
);

  localparam int CW = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);
  localparam logic [N_IN-1:0] VEC_MAX = {N_IN{1'b1}};

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_DONE} state_t;

  state_t            state_q;
  logic [CW-1:0]     cnt_q;
  logic [2:0]        sel_q;
  logic [N_IN-1:0]   vec_q;
  logic [N_FUNC-1:0] en_q;
  logic              busy_q, done_q, err_q;
  logic [15:0]       tabla_q;
  logic [3:0]        tidx;

  // vector widened to a tabla bit index (N_IN may be 3)
  assign tidx = 4'(vec_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sel_q   <= '0;
      vec_q   <= '0;
      en_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      tabla_q <= '0;
    end else begin
      // pulses default low; set only on the edge that enters the pulse cycle
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          vec_q  <= '0;
          en_q   <= '0;
          busy_q <= 1'b0;
          if (start) begin
            if (32'(func_sel) < N_FUNC) begin
              sel_q   <= func_sel;
              tabla_q <= '0;
              cnt_q   <= CW'(SETTLE);
              en_q    <= N_FUNC'(1) << func_sel;
              busy_q  <= 1'b1;
              state_q <= S_SETTLE;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        S_SETTLE: begin
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_q <= S_SAMPLE;
        end
        S_SAMPLE: begin
          tabla_q[tidx] <= unit_y[sel_q];
          if (vec_q == VEC_MAX) begin
            // counter stops at the last vector; no wrap
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            vec_q   <= vec_q + N_IN'(1);
            cnt_q   <= CW'(SETTLE);
            state_q <= S_SETTLE;
          end
        end
        S_DONE: begin
          // start is not sampled here; a new sweep needs an IDLE cycle
          vec_q   <= '0;
          en_q    <= '0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign vec_out = vec_q;
  assign unit_en = en_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign tabla   = tabla_q;
  assign err     = err_q;

endmodule

// File: tb/tb_tabla_sweep_ctrl.sv
module tb_tabla_sweep_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // dut0: N_IN=4, SETTLE=1 ; dut1: N_IN=3, SETTLE=2
  logic       start0 = 1'b0, start1 = 1'b0;
  logic [2:0] sel0 = '0, sel1 = '0;
  logic [4:0] y0, y1, en0, en1;
  logic [3:0] vec0;
  logic [2:0] vec1;
  logic       busy0, busy1, done0, done1, err0, err1;
  logic [15:0] tabla0, tabla1;

  int total = 0;
  int bad = 0;

  // unit bank model: 0 = XOR, 1 = 3-input majority, 2 = AND of all inputs
  assign y0 = {2'b00, &vec0, (vec0[0]&vec0[1])|(vec0[0]&vec0[2])|(vec0[1]&vec0[2]), ^vec0};
  assign y1 = {2'b00, &vec1, (vec1[0]&vec1[1])|(vec1[0]&vec1[2])|(vec1[1]&vec1[2]), ^vec1};

  tabla_sweep_ctrl #(.N_IN(4), .N_FUNC(5), .SETTLE(1)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .func_sel(sel0), .unit_y(y0),
    .vec_out(vec0), .unit_en(en0), .busy(busy0), .done(done0), .tabla(tabla0), .err(err0));

  tabla_sweep_ctrl #(.N_IN(3), .N_FUNC(5), .SETTLE(2)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .func_sel(sel1), .unit_y(y1),
    .vec_out(vec1), .unit_en(en1), .busy(busy1), .done(done1), .tabla(tabla1), .err(err1));

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({vec0, en0, busy0, done0, err0, tabla0} !== 28'h0) begin
      bad++;
      $display("FAIL reset_outs got vec=%h en=%h busy=%b done=%b err=%b tabla=%h want all 0",
               vec0, en0, busy0, done0, err0, tabla0);
    end
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({busy0, busy1, en0, vec0} !== 16'h0) begin
      bad++;
      $display("FAIL reset_idle got busy0=%b busy1=%b en=%h vec=%h want 0", busy0, busy1, en0, vec0);
    end
  endtask

  task automatic test_xor4();
    int n = 0;
    start0 = 1'b1; sel0 = 3'd0;
    @(posedge clk); #1;
    start0 = 1'b0;
    total++;
    if (busy0 !== 1'b1 || en0 !== 5'b00001 || vec0 !== 4'd0) begin
      bad++;
      $display("FAIL xor4_accept got busy=%b en=%b vec=%h want 1 00001 0", busy0, en0, vec0);
    end
    while (done0 !== 1'b1 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    total++;
    if (n != 32) begin
      bad++; $display("FAIL xor4_latency got %0d want 32", n);
    end
    total++;
    if (tabla0 !== 16'h6996 || busy0 !== 1'b1 || vec0 !== 4'hF) begin
      bad++;
      $display("FAIL xor4_result got tabla=%h busy=%b vec=%h want 6996 1 f", tabla0, busy0, vec0);
    end
    @(posedge clk); #1;
    total++;
    if (busy0 !== 1'b0 || done0 !== 1'b0 || vec0 !== 4'd0 || en0 !== 5'd0) begin
      bad++;
      $display("FAIL xor4_exit got busy=%b done=%b vec=%h en=%h want 0", busy0, done0, vec0, en0);
    end
    repeat (3) @(posedge clk); #1;
    total++;
    if (tabla0 !== 16'h6996) begin
      bad++; $display("FAIL xor4_hold got %h want 6996", tabla0);
    end
  endtask

  task automatic test_maj3();
    int n = 0;
    int vbad = 0;
    start1 = 1'b1; sel1 = 3'd1;
    @(posedge clk); #1;
    start1 = 1'b0;
    // after edge k of the sweep vec_out should be k/3 (each vector held 3 cycles)
    while (done1 !== 1'b1 && n < 100) begin
      if (n < 24 && vec1 !== 3'(n / 3)) vbad++;
      @(posedge clk); #1; n++;
    end
    total++;
    if (n != 24) begin
      bad++; $display("FAIL maj3_latency got %0d want 24", n);
    end
    total++;
    if (vbad != 0) begin
      bad++; $display("FAIL maj3_vec_walk got %0d bad cycles want 0", vbad);
    end
    total++;
    if (tabla1 !== 16'h00E8 || en1 !== 5'b00010) begin
      bad++; $display("FAIL maj3_result got tabla=%h en=%b want 00e8 00010", tabla1, en1);
    end
  endtask

  task automatic test_invalid();
    start0 = 1'b1; sel0 = 3'd7;
    @(posedge clk); #1;
    start0 = 1'b0;
    total++;
    if (err0 !== 1'b1 || busy0 !== 1'b0) begin
      bad++; $display("FAIL invalid_err got err=%b busy=%b want 1 0", err0, busy0);
    end
    @(posedge clk); #1;
    total++;
    if (err0 !== 1'b0 || busy0 !== 1'b0 || tabla0 !== 16'h6996) begin
      bad++;
      $display("FAIL invalid_after got err=%b busy=%b tabla=%h want 0 0 6996", err0, busy0, tabla0);
    end
  endtask

  task automatic test_start_held();
    int n = 0;
    int errs = 0;
    start0 = 1'b1; sel0 = 3'd0;
    @(posedge clk); #1;
    sel0 = 3'd2;  // start stays high, select changes mid-sweep
    while (done0 !== 1'b1 && n < 100) begin
      if (err0 !== 1'b0) errs++;
      @(posedge clk); #1; n++;
    end
    total++;
    if (n != 32 || errs != 0) begin
      bad++; $display("FAIL held_sweep got latency=%0d errs=%0d want 32 0", n, errs);
    end
    total++;
    if (tabla0 !== 16'h6996) begin
      bad++; $display("FAIL held_tabla got %h want 6996", tabla0);
    end
    @(posedge clk); #1;
    total++;
    if (busy0 !== 1'b0) begin
      bad++; $display("FAIL held_done_ignored got busy=%b want 0", busy0);
    end
    @(posedge clk); #1;
    total++;
    if (busy0 !== 1'b1 || en0 !== 5'b00100 || tabla0 !== 16'h0) begin
      bad++;
      $display("FAIL held_restart got busy=%b en=%b tabla=%h want 1 00100 0", busy0, en0, tabla0);
    end
    start0 = 1'b0;
  endtask

  task automatic test_reset_mid();
    int n = 0;
    sel0 = 3'd0;
    while (vec0 !== 4'd5 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    total++;
    if (vec0 !== 4'd5) begin
      bad++; $display("FAIL mid_reach5 got vec=%h want 5", vec0);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if (vec0 !== 4'd0 || busy0 !== 1'b0 || tabla0 !== 16'h0 || en0 !== 5'd0) begin
      bad++;
      $display("FAIL mid_reset got vec=%h busy=%b tabla=%h en=%h want 0", vec0, busy0, tabla0, en0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    n = 0;
    total++;
    if (vec0 !== 4'd0 || busy0 !== 1'b1) begin
      bad++; $display("FAIL mid_restart got vec=%h busy=%b want 0 1", vec0, busy0);
    end
    while (done0 !== 1'b1 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    total++;
    if (n != 32 || tabla0 !== 16'h6996) begin
      bad++; $display("FAIL mid_resweep got latency=%0d tabla=%h want 32 6996", n, tabla0);
    end
  endtask

  initial begin
    test_reset();
    test_xor4();
    test_maj3();
    test_invalid();
    test_start_held();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
